// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared types and destination decode for the multi-bus arbiter
//
// Purpose : header width, per-bus FSM state type and the push-mask decode
//           used by every bus lane.
// Contents: ID_W, MAX_DRVRS, bus_state_t, dest_mask().
package bus_pkg;

    localparam int ID_W      = 8;
    // Upper bound on drivers per bus; dest_mask returns a mask this wide and
    // each lane keeps only its low DRVRS bits.
    localparam int MAX_DRVRS = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } bus_state_t;

    // Broadcast reaches every driver except the source. Any ID in range
    // selects one driver, including the source itself. Any other ID yields
    // an empty mask, so the packet is dropped.
    function automatic logic [MAX_DRVRS-1:0] dest_mask(
        input logic [ID_W-1:0] id,
        input int              src,
        input int              drvrs,
        input int              broadcast
    );
        logic [MAX_DRVRS-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_DRVRS; i++) begin
            if (i < drvrs) begin
                if (int'(id) == broadcast) begin
                    m[i] = (i != src);
                end else if (i == int'(id)) begin
                    m[i] = 1'b1;
                end
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/bus_lane.sv
// rtl/bus_lane.sv - one bus: round-robin arbiter, IDLE/POP/PUSH FSM, bus register
//
// Purpose : grants one pending driver, pops its head packet, and pushes the
//           packet to the driver(s) named in its header.
// Ports   : clk, reset (async, active-low)
//           pndng_i  [DRVRS]          driver FIFO non-empty
//           d_pop_i  [DRVRS][PCKG_SZ] driver FIFO head data (first-word-fall-through)
//           pop_o    [DRVRS]          driver FIFO read strobe
//           push_o   [DRVRS]          receiver FIFO write strobe
//           d_push_o [DRVRS][PCKG_SZ] receiver FIFO data (same word for every driver)
module bus_lane
    import bus_pkg::*;
#(
    parameter int DRVRS     = 3,
    parameter int PCKG_SZ   = 16,
    parameter int BROADCAST = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [DRVRS-1:0]                pndng_i,
    input  logic [DRVRS-1:0][PCKG_SZ-1:0]   d_pop_i,
    output logic [DRVRS-1:0]                pop_o,
    output logic [DRVRS-1:0]                push_o,
    output logic [DRVRS-1:0][PCKG_SZ-1:0]   d_push_o
);

    localparam int GW = (DRVRS > 1) ? $clog2(DRVRS) : 1;

    bus_state_t           state_q, state_d;
    logic [GW-1:0]        winner_q, winner_d;
    logic [GW-1:0]        last_grant_q, last_grant_d;
    logic [PCKG_SZ-1:0]   bus_q, bus_d;
    logic [DRVRS-1:0]     pop_q, pop_d;
    logic [DRVRS-1:0]     push_q, push_d;

    logic [GW-1:0]        rr_pick;
    logic                 rr_found;
    logic [PCKG_SZ-1:0]   sel_data;
    logic [MAX_DRVRS-1:0] mask_full;

    // Search starts one past the previous grant, so a driver holding pndng
    // high waits until every other requester has been served once.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_w;
        rr_pick  = '0;
        rr_found = 1'b0;
        idx      = 0;
        idx_w    = '0;
        for (int off = 1; off <= DRVRS; off++) begin
            idx   = (int'(last_grant_q) + off) % DRVRS;
            idx_w = GW'(idx);
            if (!rr_found && pndng_i[idx_w]) begin
                rr_found = 1'b1;
                rr_pick  = idx_w;
            end
        end
    end

    assign sel_data  = d_pop_i[winner_q];
    assign mask_full = dest_mask(sel_data[PCKG_SZ-1 -: ID_W], int'(winner_q),
                                 DRVRS, BROADCAST);

    always_comb begin
        state_d      = state_q;
        winner_d     = winner_q;
        last_grant_d = last_grant_q;
        bus_d        = bus_q;
        pop_d        = '0;
        push_d       = '0;
        case (state_q)
            IDLE: begin
                if (rr_found) begin
                    winner_d       = rr_pick;
                    pop_d[rr_pick] = 1'b1;
                    state_d        = POP;
                end
            end
            POP: begin
                // Head data is valid during the pop cycle, so capture it now.
                bus_d   = sel_data;
                push_d  = mask_full[DRVRS-1:0];
                state_d = PUSH;
            end
            PUSH: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            winner_q     <= '0;
            last_grant_q <= GW'(DRVRS - 1);
            bus_q        <= '0;
            pop_q        <= '0;
            push_q       <= '0;
        end else begin
            state_q      <= state_d;
            winner_q     <= winner_d;
            last_grant_q <= last_grant_d;
            bus_q        <= bus_d;
            pop_q        <= pop_d;
            push_q       <= push_d;
        end
    end

    assign pop_o  = pop_q;
    assign push_o = push_q;

    for (genvar d = 0; d < DRVRS; d++) begin : g_dpush
        assign d_push_o[d] = bus_q;
    end

endmodule

// File: rtl/bus_gnrtr_arbiter.sv
// rtl/bus_gnrtr_arbiter.sv - BITS independent buses, each arbitrating DRVRS driver FIFOs
//
// Purpose : top level; one bus_lane per bus, no state shared between buses.
// Ports   : clk, reset (async, active-low)
//           pndng  [BITS][DRVRS]          driver FIFO non-empty
//           D_pop  [BITS][DRVRS][PCKG_SZ] driver FIFO head data
//           pop    [BITS][DRVRS]          driver FIFO read strobe
//           push   [BITS][DRVRS]          receiver FIFO write strobe
//           D_push [BITS][DRVRS][PCKG_SZ] receiver FIFO data
module bus_gnrtr_arbiter #(
    parameter int BITS      = 3,
    parameter int DRVRS     = 3,
    parameter int PCKG_SZ   = 16,
    parameter int BROADCAST = 16
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [BITS-1:0][DRVRS-1:0]              pndng,
    output logic [BITS-1:0][DRVRS-1:0]              push,
    output logic [BITS-1:0][DRVRS-1:0]              pop,
    input  logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop,
    output logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push
);

    for (genvar b = 0; b < BITS; b++) begin : g_bus
        bus_lane #(
            .DRVRS     (DRVRS),
            .PCKG_SZ   (PCKG_SZ),
            .BROADCAST (BROADCAST)
        ) u_lane (
            .clk      (clk),
            .reset    (reset),
            .pndng_i  (pndng[b]),
            .d_pop_i  (D_pop[b]),
            .pop_o    (pop[b]),
            .push_o   (push[b]),
            .d_push_o (D_push[b])
        );
    end

endmodule

// File: tb/tb_bus_gnrtr_arbiter.sv
// tb/tb_bus_gnrtr_arbiter.sv - self-checking bench for bus_gnrtr_arbiter
module tb_bus_gnrtr_arbiter;

    localparam int BITS      = 3;
    localparam int DRVRS     = 3;
    localparam int PCKG_SZ   = 16;
    localparam int BROADCAST = 16;

    logic clk = 1'b0;
    logic reset;
    logic [BITS-1:0][DRVRS-1:0]              pndng;
    logic [BITS-1:0][DRVRS-1:0]              push;
    logic [BITS-1:0][DRVRS-1:0]              pop;
    logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_pop;
    logic [BITS-1:0][DRVRS-1:0][PCKG_SZ-1:0] D_push;

    always #5 clk = ~clk;

    bus_gnrtr_arbiter #(
        .BITS      (BITS),
        .DRVRS     (DRVRS),
        .PCKG_SZ   (PCKG_SZ),
        .BROADCAST (BROADCAST)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .pndng  (pndng),
        .push   (push),
        .pop    (pop),
        .D_pop  (D_pop),
        .D_push (D_push)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: a grant at edge g means pop visible after
    // edge g, data captured and push visible after edge g+1, and the bus may
    // accept a new grant at edge g+3.
    int               edge_n;
    int               m_last  [BITS];
    int               m_free  [BITS];
    int               m_gedge [BITS];
    int               m_win   [BITS];
    bit               m_act   [BITS];
    logic [15:0]      m_data  [BITS];
    logic [DRVRS-1:0] e_pop   [BITS];
    logic [DRVRS-1:0] e_push  [BITS];

    function automatic logic [DRVRS-1:0] ref_mask(input int id, input int src);
        logic [DRVRS-1:0] all_ones;
        all_ones = '1;
        if (id == BROADCAST) return all_ones & ~(DRVRS'(1) << src);
        if (id < DRVRS)      return DRVRS'(1) << id;
        return '0;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < BITS; b++) begin
            m_last[b]  = DRVRS - 1;
            m_free[b]  = 0;
            m_gedge[b] = 0;
            m_win[b]   = 0;
            m_act[b]   = 1'b0;
            m_data[b]  = '0;
            e_pop[b]   = '0;
            e_push[b]  = '0;
        end
    endtask

    task automatic model_edge();
        edge_n++;
        for (int b = 0; b < BITS; b++) begin
            e_pop[b]  = '0;
            e_push[b] = '0;
            if (m_act[b] && edge_n == m_gedge[b] + 1) begin
                m_data[b] = D_pop[b][m_win[b]];
                e_push[b] = ref_mask(int'(m_data[b][15:8]), m_win[b]);
                m_act[b]  = 1'b0;
            end
            if (edge_n >= m_free[b] && pndng[b] != '0) begin
                for (int k = 1; k <= DRVRS; k++) begin
                    int c;
                    c = (m_last[b] + k) % DRVRS;
                    if (pndng[b][c]) begin
                        m_win[b] = c;
                        break;
                    end
                end
                m_gedge[b] = edge_n;
                m_free[b]  = edge_n + 3;
                m_last[b]  = m_win[b];
                m_act[b]   = 1'b1;
                e_pop[b]   = DRVRS'(1) << m_win[b];
            end
        end
    endtask

    task automatic compare(input string ph);
        for (int b = 0; b < BITS; b++) begin
            check($sformatf("%s pop[%0d]", ph, b), 32'(pop[b]), 32'(e_pop[b]));
            check($sformatf("%s push[%0d]", ph, b), 32'(push[b]), 32'(e_push[b]));
            for (int d = 0; d < DRVRS; d++)
                check($sformatf("%s D_push[%0d][%0d]", ph, b, d), 32'(D_push[b][d]), 32'(m_data[b]));
        end
    endtask

    task automatic step(input string ph);
        model_edge();
        @(posedge clk);
        #1;
        compare(ph);
    endtask

    task automatic check_zero(input string ph);
        for (int b = 0; b < BITS; b++) begin
            check($sformatf("%s pop[%0d]", ph, b), 32'(pop[b]), 32'd0);
            check($sformatf("%s push[%0d]", ph, b), 32'(push[b]), 32'd0);
            for (int d = 0; d < DRVRS; d++)
                check($sformatf("%s D_push[%0d][%0d]", ph, b, d), 32'(D_push[b][d]), 32'd0);
        end
    endtask

    function automatic logic [15:0] rand_pkt();
        int r;
        logic [7:0] id;
        r = $urandom_range(0, 4);
        if (r < 3)       id = 8'(r);
        else if (r == 3) id = 8'(BROADCAST);
        else             id = 8'($urandom_range(3, 255));
        return {id, 8'($urandom)};
    endfunction

    initial begin
        edge_n = 0;
        reset  = 1'b0;
        pndng  = '1;
        D_pop  = '0;
        model_reset();

        // Reset held with every driver requesting.
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b1;
        step("rst_rel");
        for (int b = 0; b < BITS; b++)
            check($sformatf("first_pop[%0d]", b), 32'(pop[b]), 32'b001);
        pndng = '0;
        repeat (3) step("drain");

        // Unicast on bus 0: driver 1 -> driver 2.
        pndng[0]    = 3'b010;
        D_pop[0][1] = 16'h0255;
        step("uni");
        check("uni_pop", 32'(pop[0]), 32'b010);
        pndng = '0;
        step("uni");
        check("uni_push", 32'(push[0]), 32'b100);
        check("uni_data", 32'(D_push[0][2]), 32'h0255);
        step("uni");

        // Broadcast on bus 1 from driver 0.
        pndng[1]    = 3'b001;
        D_pop[1][0] = 16'h10AB;
        step("bc");
        pndng = '0;
        step("bc");
        check("bc_push", 32'(push[1]), 32'b110);
        step("bc");

        // Unknown ID on bus 2: popped and dropped.
        pndng[2]    = 3'b100;
        D_pop[2][2] = 16'h07CC;
        step("inv");
        check("inv_pop", 32'(pop[2]), 32'b100);
        pndng = '0;
        step("inv");
        check("inv_push", 32'(push[2]), 32'b000);
        step("inv");

        // Round-robin with all drivers of bus 0 held pending.
        for (int d = 0; d < DRVRS; d++) D_pop[0][d] = {8'h00, 8'(d)};
        pndng[0] = 3'b111;
        repeat (12) step("rr");
        pndng = '0;
        repeat (3) step("rr_drain");

        // Randomised traffic on all buses.
        for (int i = 0; i < 600; i++) begin
            pndng = BITS*DRVRS'($urandom);
            for (int b = 0; b < BITS; b++)
                for (int d = 0; d < DRVRS; d++)
                    D_pop[b][d] = rand_pkt();
            step("rand");
        end
        pndng = '0;
        repeat (3) step("rand_drain");

        // Asynchronous reset while bus 0 is in its pop cycle.
        pndng[0] = 3'b111;
        step("mid");
        #2;
        reset = 1'b0;
        #1;
        check_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("restart");
        check("restart_pop", 32'(pop[0]), 32'b001);
        pndng = '0;
        repeat (3) step("end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
